// File: rtl/mips_ifid_pipe.sv
// rtl/mips_ifid_pipe.sv - IF->ID pipeline register with load-use hazard detection, flush kill and perf counters
`ifndef MIPS_INST_WIDTH
`define MIPS_INST_WIDTH 32
`endif
`ifndef MIPS_ADDR_WIDTH
`define MIPS_ADDR_WIDTH 32
`endif
`ifndef MIPS_RFIDX_WIDTH
`define MIPS_RFIDX_WIDTH 5
`endif

module mips_ifid_pipe #(
   parameter logic [`MIPS_INST_WIDTH-1:0] NOP_INST  = 32'h0000_0000,
   parameter int unsigned                 FLUSH_CYC = 1,
   parameter int unsigned                 CNT_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [`MIPS_INST_WIDTH-1:0]   if2id_inst,
   input  logic [`MIPS_ADDR_WIDTH-1:0]   if2id_pc_incr,
   input  logic                          if2id_prdt_taken,
   input  logic [`MIPS_RFIDX_WIDTH-1:0]  if2id_rs_idx,
   input  logic [`MIPS_RFIDX_WIDTH-1:0]  if2id_rt_idx,
   input  logic                          ext_stall,
   input  logic                          ex_flush,
   input  logic                          idex_mem_read,
   input  logic [`MIPS_RFIDX_WIDTH-1:0]  idex_rt_idx,
   output logic                          id_valid,
   output logic [`MIPS_INST_WIDTH-1:0]   id_inst,
   output logic [`MIPS_ADDR_WIDTH-1:0]   id_pc_incr,
   output logic                          id_prdt_taken,
   output logic [`MIPS_RFIDX_WIDTH-1:0]  id_rs_idx,
   output logic [`MIPS_RFIDX_WIDTH-1:0]  id_rt_idx,
   output logic                          if_stall,
   output logic                          id_bubble,
   output logic [CNT_W-1:0]              perf_stall_cnt,
   output logic [CNT_W-1:0]              perf_flush_cnt
);
   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;
   typedef enum logic [2:0] {ACT_ADVANCE, ACT_FLUSH, ACT_KILL, ACT_FREEZE, ACT_HAZARD} act_t;

   localparam logic [2:0]       KILL_INIT = 3'(FLUSH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t     state, state_nxt;
   logic [2:0] kill_cnt, kill_cnt_nxt;
   act_t       act;
   logic       load_use;

   assign load_use = id_valid & idex_mem_read & (idex_rt_idx != '0) &
                     ((id_rs_idx == idex_rt_idx) | (id_rt_idx == idex_rt_idx));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_RUN;
         kill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         kill_cnt <= kill_cnt_nxt;
      end
   end

   // kill_cnt counts the NOP cycles still owed after the current one
   always_comb begin
      state_nxt    = state;
      kill_cnt_nxt = kill_cnt;
      case (act)
         ACT_FLUSH: begin
            kill_cnt_nxt = KILL_INIT;
            state_nxt    = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
         end
         ACT_KILL: begin
            kill_cnt_nxt = (kill_cnt == 3'd0) ? 3'd0 : kill_cnt - 3'd1;
            state_nxt    = (kill_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
         end
         default: ;
      endcase
   end

   always_comb begin
      act       = ACT_ADVANCE;
      if_stall  = 1'b0;
      id_bubble = 1'b0;
      if (!rst) begin
         if (ex_flush) begin
            act = ACT_FLUSH;
         end else if (state == ST_FLUSH && !ext_stall) begin
            act = ACT_KILL;
         end else if (ext_stall) begin
            act      = ACT_FREEZE;
            if_stall = 1'b1;
         end else if (load_use) begin
            act       = ACT_HAZARD;
            if_stall  = 1'b1;
            id_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid      <= 1'b0;
         id_inst       <= NOP_INST;
         id_pc_incr    <= '0;
         id_prdt_taken <= 1'b0;
         id_rs_idx     <= '0;
         id_rt_idx     <= '0;
      end else begin
         case (act)
            ACT_FLUSH, ACT_KILL: begin
               id_valid      <= 1'b0;
               id_inst       <= NOP_INST;
               id_pc_incr    <= '0;
               id_prdt_taken <= 1'b0;
               id_rs_idx     <= '0;
               id_rt_idx     <= '0;
            end
            ACT_ADVANCE: begin
               id_valid      <= 1'b1;
               id_inst       <= if2id_inst;
               id_pc_incr    <= if2id_pc_incr;
               id_prdt_taken <= if2id_prdt_taken;
               id_rs_idx     <= if2id_rs_idx;
               id_rt_idx     <= if2id_rt_idx;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (if_stall && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + CNT_ONE;
         if (act == ACT_FLUSH && perf_flush_cnt != '1)
            perf_flush_cnt <= perf_flush_cnt + CNT_ONE;
      end
   end
endmodule

// File: tb/tb_mips_ifid_pipe.sv
// tb/tb_mips_ifid_pipe.sv - bench for mips_ifid_pipe, two parameterisations driven in lockstep
module tb_mips_ifid_pipe;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, prdt, ext_stall, ex_flush, mem_read;
   logic [31:0] inst, pc;
   logic [4:0]  rs, rt, idex_rt;

   logic        a_valid, a_prdt, a_st, a_bb;
   logic [31:0] a_inst, a_pc;
   logic [4:0]  a_rs, a_rt;
   logic [15:0] a_scnt, a_fcnt;
   logic        b_valid, b_prdt, b_st, b_bb;
   logic [31:0] b_inst, b_pc;
   logic [4:0]  b_rs, b_rt;
   logic [3:0]  b_scnt, b_fcnt;

   mips_ifid_pipe #(.NOP_INST(NOP), .FLUSH_CYC(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .if2id_inst(inst), .if2id_pc_incr(pc), .if2id_prdt_taken(prdt),
      .if2id_rs_idx(rs), .if2id_rt_idx(rt), .ext_stall(ext_stall), .ex_flush(ex_flush),
      .idex_mem_read(mem_read), .idex_rt_idx(idex_rt), .id_valid(a_valid), .id_inst(a_inst),
      .id_pc_incr(a_pc), .id_prdt_taken(a_prdt), .id_rs_idx(a_rs), .id_rt_idx(a_rt),
      .if_stall(a_st), .id_bubble(a_bb), .perf_stall_cnt(a_scnt), .perf_flush_cnt(a_fcnt));

   mips_ifid_pipe #(.NOP_INST(NOP), .FLUSH_CYC(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .if2id_inst(inst), .if2id_pc_incr(pc), .if2id_prdt_taken(prdt),
      .if2id_rs_idx(rs), .if2id_rt_idx(rt), .ext_stall(ext_stall), .ex_flush(ex_flush),
      .idex_mem_read(mem_read), .idex_rt_idx(idex_rt), .id_valid(b_valid), .id_inst(b_inst),
      .id_pc_incr(b_pc), .id_prdt_taken(b_prdt), .id_rs_idx(b_rs), .id_rt_idx(b_rt),
      .if_stall(b_st), .id_bubble(b_bb), .perf_stall_cnt(b_scnt), .perf_flush_cnt(b_fcnt));

   int tests = 0;
   int fails = 0;

   // Reference model: ID contents plus "NOP cycles still owed" and plain integer counters
   bit          m_valid[2];
   logic [31:0] m_inst[2], m_pc[2];
   bit          m_prdt[2];
   logic [4:0]  m_rs[2], m_rt[2];
   int          m_kill[2], m_scnt[2], m_fcnt[2];
   int          fcyc[2] = '{1, 2};
   int          cmax[2] = '{65535, 15};

   task automatic model_reset(input int i);
      m_valid[i] = 0; m_inst[i] = NOP; m_pc[i] = 0; m_prdt[i] = 0;
      m_rs[i] = 0; m_rt[i] = 0; m_kill[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
   endtask

   task automatic model_outs(input int i, output bit st, output bit bb);
      bit lu;
      st = 0; bb = 0;
      lu = m_valid[i] && mem_read && idex_rt != 0 && (m_rs[i] == idex_rt || m_rt[i] == idex_rt);
      if (!rst && !ex_flush) begin
         if (ext_stall) st = 1;
         else if (m_kill[i] == 0 && lu) begin st = 1; bb = 1; end
      end
   endtask

   task automatic model_step(input int i);
      bit st, bb;
      model_outs(i, st, bb);
      if (rst) begin
         model_reset(i);
      end else begin
         if (ex_flush || (m_kill[i] > 0 && !ext_stall)) begin
            if (ex_flush) begin
               m_kill[i] = fcyc[i] - 1;
               if (m_fcnt[i] < cmax[i]) m_fcnt[i]++;
            end else begin
               m_kill[i]--;
            end
            m_valid[i] = 0; m_inst[i] = NOP; m_pc[i] = 0; m_prdt[i] = 0; m_rs[i] = 0; m_rt[i] = 0;
         end else if (!st) begin
            m_valid[i] = 1; m_inst[i] = inst; m_pc[i] = pc; m_prdt[i] = prdt;
            m_rs[i] = rs; m_rt[i] = rt;
         end
         if (st && m_scnt[i] < cmax[i]) m_scnt[i]++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int i, input logic v, input logic [31:0] in,
                            input logic [31:0] p, input logic pr, input logic [4:0] s,
                            input logic [4:0] t, input logic st, input logic bb,
                            input logic [15:0] sc, input logic [15:0] fc);
      bit est, ebb;
      model_outs(i, est, ebb);
      chk({tag, ".id_valid"}, 32'(v), 32'(m_valid[i]));
      chk({tag, ".id_inst"}, in, m_inst[i]);
      chk({tag, ".id_pc_incr"}, p, m_pc[i]);
      chk({tag, ".id_prdt_taken"}, 32'(pr), 32'(m_prdt[i]));
      chk({tag, ".id_rs_idx"}, 32'(s), 32'(m_rs[i]));
      chk({tag, ".id_rt_idx"}, 32'(t), 32'(m_rt[i]));
      chk({tag, ".if_stall"}, 32'(st), 32'(est));
      chk({tag, ".id_bubble"}, 32'(bb), 32'(ebb));
      chk({tag, ".perf_stall_cnt"}, 32'(sc), m_scnt[i]);
      chk({tag, ".perf_flush_cnt"}, 32'(fc), m_fcnt[i]);
   endtask

   task automatic settle();
      @(negedge clk);
      check_dut("A", 0, a_valid, a_inst, a_pc, a_prdt, a_rs, a_rt, a_st, a_bb, a_scnt, a_fcnt);
      check_dut("B", 1, b_valid, b_inst, b_pc, b_prdt, b_rs, b_rt, b_st, b_bb,
                16'(b_scnt), 16'(b_fcnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic cycle();
      settle();
      tick();
   endtask

   task automatic idle_inputs();
      rst = 0; ext_stall = 0; ex_flush = 0; mem_read = 0; idex_rt = 0; prdt = 0;
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] inst, pc;
      logic [4:0]  rs, rt;
      logic        stall, flush, mrd;
      logic [4:0]  xrt;
      logic        e_valid;
      logic [31:0] e_inst;
      logic        e_st, e_bb;
   } vec_t;
   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 32'h8C22_0004, 32'h4,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NOP,          1'b0, 1'b0};
      tbl[1] = '{1'b0, 32'h8C22_0004, 32'h4,  5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NOP,          1'b0, 1'b0};
      tbl[2] = '{1'b0, 32'h0043_2020, 32'h8,  5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h8C22_0004, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 32'h1111_1111, 32'hC,  5'd4, 5'd5, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 32'h0043_2020, 1'b1, 1'b1};
      tbl[4] = '{1'b0, 32'h1111_1111, 32'hC,  5'd4, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0043_2020, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 32'h2222_2222, 32'h10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h1111_1111, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 32'h3333_3333, 32'h14, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 32'h2222_2222, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 32'h4444_4444, 32'h18, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 32'h3333_3333, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 32'h4444_4444, 32'h18, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, NOP,          1'b0, 1'b0};
      tbl[9] = '{1'b0, 32'h5555_5555, 32'h1C, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h4444_4444, 1'b0, 1'b0};

      idle_inputs();
      rst = 1; inst = 0; pc = 0; rs = 0; rt = 0;
      @(posedge clk);
      model_reset(0);
      model_reset(1);
      #1;

      // Directed table: reset, load-use, rt==0 exclusion, flush beating stall and load-use
      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].rst; inst = tbl[i].inst; pc = tbl[i].pc; rs = tbl[i].rs; rt = tbl[i].rt;
         ext_stall = tbl[i].stall; ex_flush = tbl[i].flush; mem_read = tbl[i].mrd;
         idex_rt = tbl[i].xrt; prdt = 1'(i & 1);
         settle();
         chk($sformatf("row%0d.id_valid", i), 32'(a_valid), 32'(tbl[i].e_valid));
         chk($sformatf("row%0d.id_inst", i), a_inst, tbl[i].e_inst);
         chk($sformatf("row%0d.if_stall", i), 32'(a_st), 32'(tbl[i].e_st));
         chk($sformatf("row%0d.id_bubble", i), 32'(a_bb), 32'(tbl[i].e_bb));
         if (i == 3) chk("row3.id_pc_incr", a_pc, 32'h8);
         if (i == 2) chk("row2.id_pc_incr", a_pc, 32'h4);
         tick();
      end
      chk("table.stall_cnt", 32'(a_scnt), 32'd1);
      chk("table.flush_cnt", 32'(a_fcnt), 32'd1);

      // FLUSH_CYC=2: two NOP cycles, then IF data resumes
      idle_inputs(); rst = 1; cycle();
      rst = 0; inst = 32'hAAAA_0000; pc = 32'h40; cycle();
      ex_flush = 1; inst = 32'hBBBB_0000; pc = 32'h44; cycle();
      ex_flush = 0; inst = 32'hCCCC_0000; pc = 32'h48; settle();
      chk("fl2.c1.valid", 32'(b_valid), 32'd0);
      chk("fl2.c1.inst", b_inst, NOP);
      tick();
      inst = 32'hDDDD_0000; pc = 32'h4C; settle();
      chk("fl2.c2.valid", 32'(b_valid), 32'd0);
      chk("fl2.c2.inst", b_inst, NOP);
      chk("fl1.c2.inst", a_inst, 32'hCCCC_0000);
      tick();
      inst = 32'hEEEE_0000; settle();
      chk("fl2.c3.inst", b_inst, 32'hDDDD_0000);
      chk("fl2.flush_cnt", 32'(b_fcnt), 32'd1);
      tick();

      // ext_stall during load-use: frozen, no bubble, then exactly one bubble cycle
      idle_inputs(); rst = 1; cycle();
      rst = 0; inst = 32'hABCD_0000; rs = 5'd9; rt = 5'd1; cycle();
      inst = 32'h1234_0000; rs = 5'd3; rt = 5'd3;
      for (int k = 0; k < 3; k++) begin
         ext_stall = 1; mem_read = 1; idex_rt = 5'd9; settle();
         chk($sformatf("xs%0d.if_stall", k), 32'(a_st), 32'd1);
         chk($sformatf("xs%0d.id_bubble", k), 32'(a_bb), 32'd0);
         chk($sformatf("xs%0d.id_inst", k), a_inst, 32'hABCD_0000);
         tick();
      end
      ext_stall = 0; settle();
      chk("lu.if_stall", 32'(a_st), 32'd1);
      chk("lu.id_bubble", 32'(a_bb), 32'd1);
      tick();
      mem_read = 0; settle();
      chk("lu.after.if_stall", 32'(a_st), 32'd0);
      chk("lu.stall_cnt", 32'(a_scnt), 32'd4);
      tick();

      // 4-bit counter saturation, then reset landing in the middle of a flush
      idle_inputs(); rst = 1; cycle();
      rst = 0; ext_stall = 1;
      for (int k = 0; k < 20; k++) cycle();
      ext_stall = 0; settle();
      chk("sat.b_stall_cnt", 32'(b_scnt), 32'hF);
      chk("sat.a_stall_cnt", 32'(a_scnt), 32'd20);
      tick();
      ex_flush = 1; cycle();
      ex_flush = 0; rst = 1; cycle();
      rst = 0; inst = 32'h7777_0000; pc = 32'h80; settle();
      chk("rstfl.valid", 32'(b_valid), 32'd0);
      chk("rstfl.stall_cnt", 32'(b_scnt), 32'd0);
      chk("rstfl.flush_cnt", 32'(b_fcnt), 32'd0);
      tick();
      inst = 32'h8888_0000; settle();
      chk("rstfl.resume", b_inst, 32'h7777_0000);
      tick();

      // Randomized traffic against the model, small index range to provoke hazards
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(63) == 0);
         ex_flush  = ($urandom_range(11) == 0);
         ext_stall = ($urandom_range(5) == 0);
         mem_read  = ($urandom_range(2) == 0);
         idex_rt   = 5'($urandom_range(3));
         rs        = 5'($urandom_range(3));
         rt        = 5'($urandom_range(3));
         inst      = $urandom;
         pc        = $urandom;
         prdt      = 1'($urandom_range(1));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
